// File: rtl/pdet_input_conditioner.sv
// Synchronise and debounce the raw data switch and trigger button for the detector.
// Define PDET_AUTOREPEAT_EN to auto-repeat trig while the button stays held.
module pdet_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_data_i,
    input  logic       btn_trig_i,
    output logic       data,
    output logic       trig,
    output logic [7:0] trig_cnt
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] db;
    logic       db_data;
    logic       db_btn;

    assign raw     = {btn_trig_i, sw_data_i};
    assign db_data = db[0];
    assign db_btn  = db[1];

    // Bit 0 is the data switch, bit 1 the trigger button.
    for (genvar g = 0; g < 2; g++) begin : g_in
        logic [SYNC_STAGES-1:0] chain;
        logic [DBW-1:0]         cnt;
        logic                   synced;
        logic                   q;

        assign synced = chain[SYNC_STAGES-1];
        assign db[g]  = q;

        always_ff @(posedge clk) begin
            if (reset) begin
                chain <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], raw[g]};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (synced == q) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt <= '0;
                q   <= synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HELD = 2'b01
    } state_t;

    state_t     state;
    state_t     state_d;
    logic       data_d;
    logic       trig_d;
    logic [7:0] trig_cnt_d;

`ifdef PDET_AUTOREPEAT_EN
    localparam int RPMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW = $clog2(RPMAX + 1);

    logic [RPW-1:0] rep_cnt;
    logic [RPW-1:0] rep_cnt_d;
    logic           rep_first;
    logic           rep_first_d;
    logic           rep_hit;

    // The first repeat waits the long delay, later ones the short period.
    assign rep_hit = rep_first ? (rep_cnt == RPW'(REPEAT_DELAY - 1))
                               : (rep_cnt == RPW'(REPEAT_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_d;
            rep_first <= rep_first_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            data     <= 1'b0;
            trig     <= 1'b0;
            trig_cnt <= '0;
        end else begin
            state    <= state_d;
            data     <= data_d;
            trig     <= trig_d;
            trig_cnt <= trig_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        data_d      = data;
        trig_d      = 1'b0;
        trig_cnt_d  = trig_cnt;
`ifdef PDET_AUTOREPEAT_EN
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
`endif
        unique case (state)
            IDLE: begin
                if (db_btn) begin
                    state_d    = HELD;
                    trig_d     = 1'b1;
                    data_d     = db_data;
                    trig_cnt_d = trig_cnt + 8'd1;
                end
            end
            HELD: begin
                if (!db_btn) begin
                    state_d = IDLE;
                end
`ifdef PDET_AUTOREPEAT_EN
                else if (rep_hit) begin
                    trig_d      = 1'b1;
                    data_d      = db_data;
                    trig_cnt_d  = trig_cnt + 8'd1;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d   = rep_cnt + 1'b1;
                    rep_first_d = rep_first;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pdet_input_conditioner.sv
// Directed bench for pdet_input_conditioner: vector table plus multi-cycle sequences.
// Define PDET_AUTOREPEAT_EN for both bench and RTL to check the repeat build.
module tb_pdet_input_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_data_i;
    logic       btn_trig_i;
    logic       data;
    logic       trig;
    logic [7:0] trig_cnt;

    int total = 0;
    int bad   = 0;
    int edge_n;
    int ntrig;
    int consec = 0;
    int trig_at[$];
    logic prev_trig = 1'b0;
    logic [7:0] exp_cnt;

    typedef struct {
        logic sw_base;
        int   sw_len;
        int   btn_len;
        int   exp_n;
        int   exp_at;
        logic exp_data;
    } vec_t;

    vec_t vt[7];

    always #5 clk = ~clk;

    pdet_input_conditioner #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_data_i (sw_data_i),
        .btn_trig_i(btn_trig_i),
        .data      (data),
        .trig      (trig),
        .trig_cnt  (trig_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic s);
        btn_trig_i = b;
        sw_data_i  = s;
        @(posedge clk);
        #1;
        edge_n++;
        if (trig === 1'b1) begin
            ntrig++;
            trig_at.push_back(edge_n);
            if (prev_trig === 1'b1) consec++;
        end
        prev_trig = trig;
    endtask

    task automatic hold(input logic b, input logic s, input int n);
        for (int i = 0; i < n; i++) step(b, s);
    endtask

    task automatic mark();
        edge_n = 0;
        ntrig  = 0;
        trig_at.delete();
    endtask

    function automatic int first_at();
        return (trig_at.size() > 0) ? trig_at[0] : -1;
    endfunction

    initial begin
        vt[0] = '{1'b1, 0, 15, 1, 7, 1'b1};
        vt[1] = '{1'b0, 0,  3, 0, 0, 1'b1};
        vt[2] = '{1'b0, 0,  4, 1, 7, 1'b0};
        vt[3] = '{1'b0, 3, 10, 1, 7, 1'b0};
        vt[4] = '{1'b0, 4, 10, 1, 7, 1'b1};
        vt[5] = '{1'b0, 0,  6, 1, 7, 1'b0};
        vt[6] = '{1'b1, 3,  0, 0, 0, 1'b0};

        reset = 1'b1;
        mark();
        for (int i = 0; i < 11; i++) begin
            step(1'(i % 2), 1'((i / 2) % 2));
            check("reset_outputs", {22'd0, data, trig, trig_cnt}, 32'd0);
        end
        reset = 1'b0;
        mark();
        hold(1'b0, 1'b0, 50);
        check("idle_no_trig", ntrig, 0);

        exp_cnt = 8'd0;
        for (int v = 0; v < 7; v++) begin
            hold(1'b0, vt[v].sw_base, 10);
            mark();
            for (int i = 0; i < 24; i++) begin
                step(i < vt[v].btn_len,
                     (i < vt[v].sw_len) ? ~vt[v].sw_base : vt[v].sw_base);
            end
            hold(1'b0, vt[v].sw_base, 4);
            exp_cnt = exp_cnt + 8'(vt[v].exp_n);
            check($sformatf("vec%0d_ntrig", v), ntrig, vt[v].exp_n);
            if (vt[v].exp_n > 0)
                check($sformatf("vec%0d_at", v), first_at(), vt[v].exp_at);
            check($sformatf("vec%0d_data", v), data, vt[v].exp_data);
            check($sformatf("vec%0d_cnt", v), trig_cnt, exp_cnt);
        end

        hold(1'b0, 1'b1, 10);
        mark();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        hold(1'b1, 1'b1, 15);
        hold(1'b0, 1'b1, 14);
        exp_cnt = exp_cnt + 8'd1;
        check("bounce_ntrig", ntrig, 1);
        check("bounce_at", first_at(), 12);
        check("bounce_cnt", trig_cnt, exp_cnt);
        check("bounce_data", data, 1'b1);

        hold(1'b1, 1'b0, 3);
        reset = 1'b1;
        hold(1'b1, 1'b0, 2);
        check("midreset_cnt", trig_cnt, 0);
        reset = 1'b0;
        mark();
        hold(1'b1, 1'b0, 15);
        hold(1'b0, 1'b0, 14);
        check("midreset_ntrig", ntrig, 1);
        check("midreset_at", first_at(), 7);
        check("midreset_cnt_after", trig_cnt, 1);

        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        hold(1'b0, 1'b1, 10);
        mark();
        hold(1'b1, 1'b1, 10);
        hold(1'b1, 1'b0, 10);
        check("held_data_kept", data, 1'b1);
        hold(1'b0, 1'b0, 14);
        hold(1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 14);
        check("second_data", data, 1'b0);
        check("second_cnt", trig_cnt, 2);
        mark();
        for (int p = 0; p < 254; p++) begin
            hold(1'b1, 1'b0, 6);
            hold(1'b0, 1'b0, 10);
        end
        check("wrap_ntrig", ntrig, 254);
        check("wrap_cnt", trig_cnt, 0);

        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
        hold(1'b0, 1'b0, 5);
        mark();
        hold(1'b1, 1'b0, 64);
        hold(1'b0, 1'b0, 14);
`ifdef PDET_AUTOREPEAT_EN
        check("repeat_ntrig", ntrig, 7);
        for (int k = 1; k < 7; k++) begin
            check($sformatf("repeat_off%0d", k),
                  (trig_at.size() > k) ? trig_at[k] - first_at() : -1,
                  RD + (k - 1) * RP);
        end
`else
        check("repeat_ntrig", ntrig, 1);
`endif
        check("repeat_first_at", first_at(), 7);

        check("no_back_to_back", consec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
